// File: rtl/bf16_add_sequencer_if.sv
// Operand/result bundle between the scheduler, the bf16 add sequencer and the adder.
// master = sequencer side, slave = environment (scheduler, consumer, adder) side.
interface bf16_add_sequencer_if;
  // Valid/ready: a transfer happens in a cycle where valid and ready are both high;
  // the source holds data stable while valid is high and ready is low.
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic        add_ready;

  modport master (
    input  in_valid, in_a, in_b, out_ready, add_sum, add_ready,
    output in_ready, out_valid, out_sum, add_a, add_b
  );

  modport slave (
    output in_valid, in_a, in_b, out_ready, add_sum, add_ready,
    input  in_ready, out_valid, out_sum, add_a, add_b
  );
endinterface

// File: rtl/bf16_add_sequencer.sv
// Drives the three-phase bfloat16 adder from an operand stream and queues its sums.
// Optional BF16SEQ_SYNC_CHECK_EN adds a sticky sync_err output and resyncs on early add_ready.
module bf16_add_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  nreset,
  bf16_add_sequencer_if.master  bus,
`ifdef BF16SEQ_SYNC_CHECK_EN
  output logic                  sync_err,
`endif
  output logic [1:0]            phase_dbg
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_A    = 2'd1,
    PH_B    = 2'd2,
    PH_CAP  = 2'd3
  } phase_e;

  phase_e          phase_q, phase_d;
  logic            capture, room, accept, push, pop;
  logic [CW:0]     occupancy;
  logic            inflight_q, inflight_d;
  logic [15:0]     hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic [15:0]     mem_q [DEPTH];
  logic [15:0]     mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) phase_q <= PH_SYNC;
    else         phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_SYNC: if (bus.add_ready) phase_d = PH_A;
      PH_A:    phase_d = PH_B;
      PH_B:    phase_d = PH_CAP;
      PH_CAP:  phase_d = bus.add_ready ? PH_A : PH_SYNC;
      default: phase_d = PH_SYNC;
    endcase
`ifdef BF16SEQ_SYNC_CHECK_EN
    if (bus.add_ready) phase_d = PH_A;
`endif
  end

  // Accept credit uses registered count only: a pop in this cycle is not credited.
  always_comb begin
`ifdef BF16SEQ_SYNC_CHECK_EN
    capture = bus.add_ready;
`else
    capture = bus.add_ready && (phase_q == PH_SYNC || phase_q == PH_CAP);
`endif
    occupancy     = (CW+1)'(count_q) + (CW+1)'(inflight_q);
    room          = occupancy < (CW+1)'(DEPTH);
    bus.in_ready  = nreset && capture && room;
    bus.out_valid = (count_q != '0);
    accept        = bus.in_valid && bus.in_ready;
    push          = capture && inflight_q;
    pop           = bus.out_valid && bus.out_ready;
  end

  always_comb begin
    inflight_d = inflight_q;
    hold_a_d   = hold_a_q;
    hold_b_d   = hold_b_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.add_sum;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      inflight_d      = 1'b0;
    end
    if (accept) begin
      hold_a_d   = bus.in_a;
      hold_b_d   = bus.in_b;
      inflight_d = 1'b1;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      inflight_q <= 1'b0;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      inflight_q <= inflight_d;
      hold_a_q   <= hold_a_d;
      hold_b_q   <= hold_b_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

`ifdef BF16SEQ_SYNC_CHECK_EN
  logic sync_err_q, sync_err_d;

  always_comb begin
    sync_err_d = sync_err_q;
    if ((bus.add_ready && (phase_q == PH_A || phase_q == PH_B)) ||
        (!bus.add_ready && phase_q == PH_CAP))
      sync_err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) sync_err_q <= 1'b0;
    else         sync_err_q <= sync_err_d;
  end

  assign sync_err = sync_err_q;
`endif

  assign bus.add_a   = hold_a_q;
  assign bus.add_b   = hold_b_q;
  assign bus.out_sum = mem_q[rd_ptr_q];
  assign phase_dbg   = phase_q;
endmodule
